// File: rtl/alu_lockstep_sched.sv
// Lockstep scheduler for the dual 4-bit ALU macro: Wishbone-programmed command FIFO,
// simultaneous issue to both ALUs, result/carry comparison, op and mismatch counting.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  ST_IDLE  | nothing in flight; waits for enable with a queued command
//  ST_ISSUE | pops FIFO head onto the shared operand outputs
//  ST_WAIT  | counts down the ALU result latency
//  ST_CHECK | compares both ALUs, updates counters and mismatch snapshot
module alu_lockstep_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int ALU_LAT    = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [1:0]  alu_sel,
    input  logic [3:0]  alu_out1,
    input  logic [3:0]  alu_out2,
    input  logic        carry1,
    input  logic        carry2,
    output logic        irq
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = CW'(ALU_LAT - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_CHECK} state_t;
    state_t state, state_nxt;

    logic          ack_q;
    logic          enable, irq_en, overflow, mismatch;
    logic [7:0]    done_cnt;
    logic [15:0]   err_cnt;
    logic [9:0]    err_snap;
    logic [9:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic [CW-1:0] wait_cnt;

    logic [1:0] reg_sel;
    logic       ctrl_wr, cmd_wr, clear, empty, full, pop, push_ok, alu_diff;
    logic       unused_ok;

    assign reg_sel   = wbs_adr_i[3:2];
    assign ctrl_wr   = ack_q & wbs_we_i & (reg_sel == 2'd0);
    assign cmd_wr    = ack_q & wbs_we_i & (reg_sel == 2'd1);
    assign clear     = ctrl_wr & wbs_dat_i[2];
    assign empty     = (fifo_cnt == '0);
    assign full      = (fifo_cnt == FULL_CNT);
    // A push into a full FIFO still fits when the head leaves on the same edge.
    assign push_ok   = cmd_wr & (~full | pop);
    assign alu_diff  = (alu_out1 != alu_out2) | (carry1 != carry2);
    assign wbs_ack_o = ack_q;
    assign irq       = irq_en & mismatch;
    assign unused_ok = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:10]};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            ST_IDLE:  if (enable && !empty) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                pop       = ~clear;
                state_nxt = ST_WAIT;
            end
            ST_WAIT:  if (wait_cnt <= CW'(1)) state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = (enable && !empty) ? ST_ISSUE : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (clear) state_nxt = ST_IDLE;
    end

    always_ff @(posedge wb_clk_i) begin
        if (push_ok) fifo_mem[wr_ptr] <= wbs_dat_i[9:0];
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            enable   <= 1'b0;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
            mismatch <= 1'b0;
            done_cnt <= '0;
            err_cnt  <= '0;
            err_snap <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            wait_cnt <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= '0;
        end else begin
            ack_q <= wbs_stb_i & wbs_cyc_i & ~ack_q;
            if (ctrl_wr) begin
                enable <= wbs_dat_i[0];
                irq_en <= wbs_dat_i[1];
            end
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (cmd_wr && full && !pop) overflow <= 1'b1;
            if (pop) begin
                rd_ptr                  <= rd_ptr + AW'(1);
                {alu_sel, alu_b, alu_a} <= fifo_mem[rd_ptr];
            end
            if (push_ok && !pop)      fifo_cnt <= fifo_cnt + (AW+1)'(1);
            else if (pop && !push_ok) fifo_cnt <= fifo_cnt - (AW+1)'(1);
            if (state == ST_ISSUE)                   wait_cnt <= WAIT_LOAD;
            else if (state == ST_WAIT && wait_cnt != '0) wait_cnt <= wait_cnt - CW'(1);
            if (state == ST_CHECK) begin
                done_cnt <= done_cnt + 8'd1;
                if (alu_diff) begin
                    mismatch <= 1'b1;
                    if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                    err_snap <= {carry2, carry1, alu_out2, alu_out1};
                end
            end
            // Clear overrides any same-edge CHECK update; operand outputs are left alone.
            if (clear) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
                overflow <= 1'b0;
                mismatch <= 1'b0;
                done_cnt <= '0;
                err_cnt  <= '0;
                err_snap <= '0;
            end
        end
    end

    always_comb begin
        wbs_dat_o = '0;
        if (ack_q && !wbs_we_i) begin
            case (reg_sel)
                2'd0:    wbs_dat_o = {30'd0, irq_en, enable};
                2'd2:    wbs_dat_o = {16'd0, done_cnt, 3'd0, mismatch, overflow, full, empty,
                                      state != ST_IDLE};
                2'd3:    wbs_dat_o = {6'd0, err_snap, err_cnt};
                default: wbs_dat_o = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_lockstep_sched.sv
// Bench for alu_lockstep_sched: table-driven single ops, hand-timed corner sequences and
// a randomized run against an op-level reference model of the lockstep checker.
module tb_alu_lockstep_sched;
    localparam int FIFO_DEPTH = 4;
    localparam int ALU_LAT    = 2;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [3:0]  alu_a, alu_b, alu_out1, alu_out2;
    logic [1:0]  alu_sel;
    logic        carry1, carry2, irq;

    int checks = 0;
    int errors = 0;
    logic [1:0] corrupt_mode = 2'd0;
    logic [4:0] alu_r;

    alu_lockstep_sched #(.FIFO_DEPTH(FIFO_DEPTH), .ALU_LAT(ALU_LAT)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out1(alu_out1), .alu_out2(alu_out2),
        .carry1(carry1), .carry2(carry2), .irq(irq)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] s);
        case (s)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {1'b0, a} - {1'b0, b};
            2'd2:    return {1'b0, a ^ b};
            default: return {1'b0, a & b};
        endcase
    endfunction

    // Corruption modes: 0 none, 1 out2 bit0 flipped, 2 carry2 flipped, 3 out2 flipped when a[3:2]==3
    function automatic logic [9:0] snap_of(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] s, input logic [1:0] ct);
        logic [4:0] r;
        logic [3:0] o2;
        logic       c2;
        r  = alu_f(a, b, s);
        o2 = r[3:0];
        c2 = r[4];
        if (ct == 2'd1 || (ct == 2'd3 && a[3:2] == 2'b11)) o2 = o2 ^ 4'h1;
        if (ct == 2'd2) c2 = ~c2;
        return {c2, r[4], o2, r[3:0]};
    endfunction

    function automatic logic [31:0] status_w(input logic [7:0] done, input logic mism,
                                             input logic ovf, input logic full,
                                             input logic empty, input logic busy);
        return {16'd0, done, 3'd0, mism, ovf, full, empty, busy};
    endfunction

    assign alu_r = alu_f(alu_a, alu_b, alu_sel);
    always_comb begin
        alu_out1 = alu_r[3:0];
        carry1   = alu_r[4];
        alu_out2 = alu_r[3:0];
        carry2   = alu_r[4];
        case (corrupt_mode)
            2'd1:    alu_out2 = alu_r[3:0] ^ 4'h1;
            2'd2:    carry2   = ~alu_r[4];
            2'd3:    if (alu_a[3:2] == 2'b11) alu_out2 = alu_r[3:0] ^ 4'h1;
            default: ;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge wb_clk_i);
    endtask

    task automatic wb_xfer(input logic we, input logic [1:0] r, input logic [31:0] d,
                           output logic [31:0] rd);
        int n;
        wbs_adr_i = {28'd0, r, 2'b00};
        wbs_dat_i = d;
        wbs_we_i  = we;
        wbs_sel_i = 4'hF;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        n = 0;
        @(negedge wb_clk_i);
        while (!wbs_ack_o && n < 4) begin
            @(negedge wb_clk_i);
            n++;
        end
        chk("wb_ack", {31'd0, wbs_ack_o}, 32'd1);
        rd = wbs_dat_o;
        @(negedge wb_clk_i);
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic wb_write(input logic [1:0] r, input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(1'b1, r, d, dummy);
    endtask

    task automatic wb_read(input logic [1:0] r, output logic [31:0] d);
        wb_xfer(1'b0, r, 32'd0, d);
    endtask

    function automatic logic [31:0] cmd_w(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] s);
        return {22'd0, s, b, a};
    endfunction

    typedef struct {
        logic [3:0]  a;
        logic [3:0]  b;
        logic [1:0]  sel;
        logic [1:0]  ct;
        logic [7:0]  exp_done;
        logic [15:0] exp_errs;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [31:0] rd;
        logic [9:0]  exp_snap;
        logic [7:0]  m_done;
        logic [15:0] m_errs;
        logic        m_mism;
        int          n;

        vecs[0] = '{4'd3,  4'd5,  2'd1, 2'd0, 8'd1, 16'd0};
        vecs[1] = '{4'd9,  4'd4,  2'd0, 2'd1, 8'd2, 16'd1};
        vecs[2] = '{4'd15, 4'd1,  2'd0, 2'd2, 8'd3, 16'd2};
        vecs[3] = '{4'd6,  4'd6,  2'd2, 2'd0, 8'd4, 16'd2};
        vecs[4] = '{4'd12, 4'd10, 2'd3, 2'd1, 8'd5, 16'd3};

        wb_rst_i = 1'b1;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = '0;   wbs_dat_i = '0;
        idle(3);
        wb_rst_i = 1'b0;
        idle(1);

        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        chk("rst_dat", wbs_dat_o, 32'd0);
        chk("rst_ops", {22'd0, alu_sel, alu_b, alu_a}, 32'd0);
        wb_read(2'd0, rd); chk("rst_ctrl", rd, 32'd0);
        wb_read(2'd1, rd); chk("rst_cmd", rd, 32'd0);
        wb_read(2'd2, rd); chk("rst_status", rd, status_w(8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        wb_read(2'd3, rd); chk("rst_err", rd, 32'd0);

        wb_write(2'd0, 32'h3);
        wb_read(2'd0, rd); chk("ctrl_rb", rd, 32'h3);
        exp_snap = '0;
        for (int i = 0; i < 5; i++) begin
            corrupt_mode = vecs[i].ct;
            wb_write(2'd1, cmd_w(vecs[i].a, vecs[i].b, vecs[i].sel));
            idle(10);
            if (vecs[i].ct != 2'd0) exp_snap = snap_of(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].ct);
            chk("vec_ops", {22'd0, alu_sel, alu_b, alu_a},
                {22'd0, vecs[i].sel, vecs[i].b, vecs[i].a});
            wb_read(2'd2, rd);
            chk("vec_status", rd, status_w(vecs[i].exp_done, vecs[i].exp_errs != 0,
                                           1'b0, 1'b0, 1'b1, 1'b0));
            wb_read(2'd3, rd);
            chk("vec_err", rd, {6'd0, exp_snap, vecs[i].exp_errs});
            chk("vec_irq", {31'd0, irq}, {31'd0, vecs[i].exp_errs != 0});
        end

        // mismatch IRQ appears the cycle after CHECK, ALU_LAT+2 cycles after the CMD ack
        wb_write(2'd0, 32'h7);
        chk("clr_irq", {31'd0, irq}, 32'd0);
        corrupt_mode = 2'd1;
        wb_write(2'd1, cmd_w(4'd2, 4'd7, 2'd2));
        n = 1;
        while (!irq && n < 20) begin
            @(negedge wb_clk_i);
            n++;
        end
        chk("op_latency", n, ALU_LAT + 3);
        wb_read(2'd2, rd); chk("lat_status", rd, status_w(8'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));

        // overflow with enable off, then drain
        corrupt_mode = 2'd0;
        wb_write(2'd0, 32'h4);
        for (int i = 0; i < 5; i++) wb_write(2'd1, cmd_w(4'(i + 1), 4'(i + 2), 2'(i)));
        wb_read(2'd2, rd); chk("ovf_status", rd, status_w(8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        wb_write(2'd0, 32'h1);
        idle(30);
        wb_read(2'd2, rd); chk("drain_status", rd, status_w(8'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        chk("drain_ops", {22'd0, alu_sel, alu_b, alu_a}, cmd_w(4'd4, 4'd5, 2'd3));

        // clear whose ack edge closes the WAIT cycle
        wb_write(2'd0, 32'h7);
        corrupt_mode = 2'd1;
        wb_write(2'd1, cmd_w(4'd1, 4'd1, 2'd0));
        idle(10);
        chk("pre_clr_irq", {31'd0, irq}, 32'd1);
        wb_write(2'd1, cmd_w(4'd5, 4'd3, 2'd1));
        idle(1);
        wb_write(2'd0, 32'h5);
        chk("wclr_irq", {31'd0, irq}, 32'd0);
        idle(10);
        wb_read(2'd2, rd); chk("wclr_status", rd, status_w(8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        wb_read(2'd3, rd); chk("wclr_err", rd, 32'd0);
        wb_read(2'd0, rd); chk("wclr_ctrl", rd, 32'h1);

        // clear landing on CHECK with a second command queued
        wb_write(2'd0, 32'h7);
        wb_write(2'd1, cmd_w(4'd8, 4'd2, 2'd0));
        wb_write(2'd1, cmd_w(4'd9, 4'd3, 2'd0));
        wb_write(2'd0, 32'h7);
        idle(10);
        wb_read(2'd2, rd); chk("cclr_status", rd, status_w(8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        wb_read(2'd3, rd); chk("cclr_err", rd, 32'd0);
        chk("cclr_irq", {31'd0, irq}, 32'd0);
        chk("cclr_ops", {22'd0, alu_sel, alu_b, alu_a}, cmd_w(4'd8, 4'd2, 2'd0));

        // push accepted on the pop edge while full
        corrupt_mode = 2'd0;
        wb_write(2'd0, 32'h4);
        for (int i = 0; i < 4; i++) wb_write(2'd1, cmd_w(4'(i), 4'(i + 8), 2'd0));
        wb_read(2'd2, rd); chk("full_status", rd, status_w(8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        wb_write(2'd0, 32'h1);
        wb_write(2'd1, cmd_w(4'd11, 4'd13, 2'd2));
        idle(30);
        wb_read(2'd2, rd); chk("pushpop_status", rd, status_w(8'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        chk("pushpop_ops", {22'd0, alu_sel, alu_b, alu_a}, cmd_w(4'd11, 4'd13, 2'd2));

        // err_cnt saturation from a preloaded value
        wb_write(2'd0, 32'h3);
        force dut.err_cnt = 16'hFFFE;
        idle(1);
        release dut.err_cnt;
        wb_read(2'd3, rd); chk("sat_preload", {16'd0, rd[15:0]}, 32'h0000FFFE);
        corrupt_mode = 2'd1;
        wb_write(2'd1, cmd_w(4'd4, 4'd4, 2'd0));
        idle(10);
        wb_read(2'd3, rd); chk("sat_reach", {16'd0, rd[15:0]}, 32'h0000FFFF);
        wb_write(2'd1, cmd_w(4'd7, 4'd1, 2'd3));
        idle(10);
        wb_read(2'd3, rd); chk("sat_hold", rd, {6'd0, snap_of(4'd7, 4'd1, 2'd3, 2'd1), 16'hFFFF});
        wb_read(2'd2, rd); chk("sat_status", rd, status_w(8'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));

        // randomized op stream against an op-level model (done_cnt wraps past 255)
        wb_write(2'd0, 32'h7);
        corrupt_mode = 2'd3;
        m_done = '0; m_errs = '0; m_mism = 1'b0; exp_snap = '0;
        for (int k = 0; k < 300; k++) begin
            logic [3:0] a, b;
            logic [1:0] s;
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            s = 2'($urandom_range(0, 3));
            wb_write(2'd1, cmd_w(a, b, s));
            m_done = m_done + 8'd1;
            if (a[3:2] == 2'b11) begin
                m_errs   = m_errs + 16'd1;
                m_mism   = 1'b1;
                exp_snap = snap_of(a, b, s, 2'd3);
            end
            idle($urandom_range(1, 5));
            if (k % 100 == 99) begin
                idle(20);
                wb_read(2'd2, rd); chk("rnd_status", rd, status_w(m_done, m_mism, 1'b0, 1'b0, 1'b1, 1'b0));
                wb_read(2'd3, rd); chk("rnd_err", rd, {6'd0, exp_snap, m_errs});
                chk("rnd_irq", {31'd0, irq}, {31'd0, m_mism});
            end
        end

        // reset in the middle of an op
        corrupt_mode = 2'd1;
        wb_write(2'd1, cmd_w(4'd15, 4'd15, 2'd1));
        idle(2);
        wb_rst_i = 1'b1;
        idle(2);
        wb_rst_i = 1'b0;
        idle(10);
        chk("mrst_irq", {31'd0, irq}, 32'd0);
        chk("mrst_ops", {22'd0, alu_sel, alu_b, alu_a}, 32'd0);
        wb_read(2'd2, rd); chk("mrst_status", rd, status_w(8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        wb_read(2'd3, rd); chk("mrst_err", rd, 32'd0);
        wb_read(2'd0, rd); chk("mrst_ctrl", rd, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
